// File: rtl/proc_core.sv
// rtl/proc_core.sv - multicycle 8-opcode processor core with registered memory interface
// R0..R6 general purpose, R7 is the PC; fetch F0..F2, execute E0..E2
module proc_core #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic [DATA_W-1:0] din,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] dout,
   output logic              wr,
   output logic              done,
   output logic [ADDR_W-1:0] pc,
   output logic [2:0]        flags
);
   typedef enum logic [2:0] {IDLE, F0, F1, F2, E0, E1, E2} state_t;

   localparam logic [2:0] OP_MV  = 3'd0;
   localparam logic [2:0] OP_B   = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_SUB = 3'd3;
   localparam logic [2:0] OP_LD  = 3'd4;
   localparam logic [2:0] OP_ST  = 3'd5;
   localparam logic [2:0] OP_AND = 3'd6;
   localparam logic [2:0] OP_MVT = 3'd7;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] r_q [0:6];
   logic [DATA_W-1:0] r_d [0:6];
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] a_q, a_d, g_q, g_d, ir_q, ir_d;
   logic              carry_q, carry_d;
   logic [2:0]        flags_q, flags_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              wr_q, wr_d, done_q, done_d;

   logic [2:0]        op, rx, ry, din_op;
   logic              imm_f, is_alu, taken, wen;
   logic [DATA_W-8:0] imm;
   logic [DATA_W-1:0] pc_ext, rx_val, ry_val, b_val, imm_zx, imm_sx, wval;
   logic [DATA_W:0]   sum;

   assign op     = ir_q[DATA_W-1 -: 3];
   assign imm_f  = ir_q[DATA_W-4];
   assign rx     = ir_q[DATA_W-5 -: 3];
   assign ry     = ir_q[2:0];
   assign imm    = ir_q[DATA_W-8:0];
   assign din_op = din[DATA_W-1 -: 3];
   assign is_alu = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
   assign imm_zx = {7'b0, imm};
   assign imm_sx = {{7{imm[DATA_W-8]}}, imm};

   always_comb begin
      pc_ext = '0;
      pc_ext[ADDR_W-1:0] = pc_q;
   end

   assign rx_val = (rx == 3'd7) ? pc_ext : r_q[rx];
   assign ry_val = (ry == 3'd7) ? pc_ext : r_q[ry];
   assign b_val  = imm_f ? imm_zx : ry_val;

   // rX field doubles as the branch condition code
   always_comb begin
      case (rx)
         3'd0:    taken = 1'b1;
         3'd1:    taken = flags_q[1];
         3'd2:    taken = !flags_q[1];
         3'd3:    taken = !flags_q[0];
         3'd4:    taken = flags_q[0];
         3'd5:    taken = !flags_q[2];
         3'd6:    taken = flags_q[2];
         default: taken = 1'b0;
      endcase
   end

   // Subtract as A + ~B + 1 so the carry reads 1 when no borrow occurs
   always_comb begin
      case (op)
         OP_ADD:  sum = {1'b0, a_q} + {1'b0, b_val};
         OP_SUB:  sum = {1'b0, a_q} + {1'b0, ~b_val} + {{DATA_W{1'b0}}, 1'b1};
         default: sum = {1'b0, a_q & b_val};
      endcase
   end

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      pc_d    = pc_q;
      a_d     = a_q;
      g_d     = g_q;
      carry_d = carry_q;
      ir_d    = ir_q;
      flags_d = flags_q;
      addr_d  = addr_q;
      dout_d  = dout_q;
      wr_d    = 1'b0;
      done_d  = 1'b0;
      wen     = 1'b0;
      wval    = g_q;
      case (state_q)
         IDLE: if (run) state_d = F0;
         F0: begin
            addr_d  = pc_q;
            pc_d    = pc_q + ADDR_W'(1);
            state_d = F1;
         end
         F1: state_d = F2;
         F2: begin
            ir_d    = din;
            state_d = E0;
            done_d  = (din_op == OP_MV) || (din_op == OP_B) || (din_op == OP_MVT);
         end
         E0: begin
            state_d = E1;
            case (op)
               OP_MV:  begin wen = 1'b1; wval = b_val; end
               OP_MVT: begin wen = 1'b1; wval = {imm, 7'b0}; end
               OP_B:   if (taken) pc_d = pc_q + imm_sx[ADDR_W-1:0];
               OP_LD:  addr_d = ry_val[ADDR_W-1:0];
               OP_ST: begin
                  addr_d = ry_val[ADDR_W-1:0];
                  dout_d = rx_val;
                  wr_d   = 1'b1;
                  done_d = 1'b1;
               end
               default: a_d = rx_val;
            endcase
         end
         E1: begin
            state_d = E2;
            done_d  = (op != OP_ST);
            if (is_alu) begin
               g_d     = sum[DATA_W-1:0];
               carry_d = sum[DATA_W];
            end
         end
         E2: begin
            wen  = 1'b1;
            wval = is_alu ? g_q : din;
            if (is_alu) flags_d = {g_q[DATA_W-1], (g_q == '0), carry_q};
         end
         default: state_d = IDLE;
      endcase
      // done_q marks the last execute cycle, where run decides whether to keep going
      if (done_q) state_d = run ? F0 : IDLE;
      if (wen) begin
         if (rx == 3'd7) pc_d = wval[ADDR_W-1:0];
         else            r_d[rx] = wval;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         for (int i = 0; i < 7; i++) r_q[i] <= '0;
         pc_q    <= '0;
         a_q     <= '0;
         g_q     <= '0;
         carry_q <= 1'b0;
         ir_q    <= '0;
         flags_q <= '0;
         addr_q  <= '0;
         dout_q  <= '0;
         wr_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         pc_q    <= pc_d;
         a_q     <= a_d;
         g_q     <= g_d;
         carry_q <= carry_d;
         ir_q    <= ir_d;
         flags_q <= flags_d;
         addr_q  <= addr_d;
         dout_q  <= dout_d;
         wr_q    <= wr_d;
         done_q  <= done_d;
      end
   end

   assign addr  = addr_q;
   assign dout  = dout_q;
   assign wr    = wr_q;
   assign done  = done_q;
   assign pc    = pc_q;
   assign flags = flags_q;
endmodule

// File: tb/tb_proc_core.sv
// tb/tb_proc_core.sv - scoreboard bench for proc_core with a one-cycle-latency memory model
module tb_proc_core;
   typedef struct packed {
      logic [7:0]  addr;
      logic [15:0] dout;
      logic        wr;
      logic        done;
      logic [7:0]  pc;
      logic [2:0]  flags;
   } snap_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        run = 1'b0;
   logic [15:0] din;
   logic [7:0]  addr, pc;
   logic [15:0] dout;
   logic        wr, done;
   logic [2:0]  flags;

   logic [15:0] mem [0:255];
   logic        ld_en = 1'b0;
   logic [7:0]  ld_a = '0;
   logic [15:0] ld_d = '0;

   logic [10:0] exp_done [$];
   logic [23:0] exp_wr [$];
   int          exp_cyc [$];
   snap_t       snap_q [$];

   int checks = 0;
   int failures = 0;
   int tmo = 0;
   int cyc = 0;
   int snap_id = 0;
   logic end_req = 1'b0;
   logic pend = 1'b0;
   logic wr_prev = 1'b0;

   proc_core #(.DATA_W(16), .ADDR_W(8)) dut (
      .clk(clk), .reset(reset), .run(run), .din(din),
      .addr(addr), .dout(dout), .wr(wr), .done(done), .pc(pc), .flags(flags)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ld_en) mem[ld_a] <= ld_d;
      else if (wr) mem[addr] <= dout;
      din <= mem[addr];
   end

   always @(posedge clk or posedge reset) begin
      if (reset) cyc <= 0;
      else cyc <= cyc + 1;
   end

   // Monitor: owns every comparison and the summary
   always @(negedge clk) begin
      snap_t s;
      logic [10:0] ed;
      logic [23:0] ew;
      int ec;
      if (snap_q.size() > 0) begin
         s = snap_q.pop_front();
         checks++;
         if ({addr, dout, wr, done, pc, flags} !== s) begin
            failures++;
            $display("FAIL snapshot%0d got=%h want=%h", snap_id, {addr, dout, wr, done, pc, flags}, s);
         end
         snap_id++;
      end
      if (reset) begin
         pend = 1'b0;
         wr_prev = 1'b0;
      end else begin
         if (pend) begin
            checks++;
            if (exp_done.size() == 0) begin
               failures++;
               $display("FAIL done_unexpected got pc=%h flags=%b want=none", pc, flags);
            end else begin
               ed = exp_done.pop_front();
               if ({pc, flags} !== ed)  begin
                  failures++;
                  $display("FAIL after_instr got pc=%h flags=%b want pc=%h flags=%b", pc, flags, ed[10:3], ed[2:0]);
               end
            end
         end
         pend = done;
         if (done && exp_cyc.size() > 0) begin
            ec = exp_cyc.pop_front();
            checks++;
            if (cyc != ec) begin
               failures++;
               $display("FAIL done_cycle got=%0d want=%0d", cyc, ec);
            end
         end
         if (wr_prev) begin
            checks++;
            if (wr) begin
               failures++;
               $display("FAIL wr_width got=wr still high want=one cycle");
            end
         end
         if (wr && !wr_prev) begin
            checks++;
            if (exp_wr.size() == 0) begin
               failures++;
               $display("FAIL wr_unexpected got addr=%h dout=%h want=none", addr, dout);
            end else begin
               ew = exp_wr.pop_front();
               if ({addr, dout} !== ew) begin
                  failures++;
                  $display("FAIL mem_write got addr=%h dout=%h want addr=%h dout=%h", addr, dout, ew[23:16], ew[15:0]);
               end
            end
         end
         wr_prev = wr;
      end
      if (end_req) begin
         checks++;
         if (tmo != 0) begin
            failures++;
            $display("FAIL timeout got=%0d expired waits want=0", tmo);
         end
         checks++;
         if (exp_done.size() != 0 || exp_wr.size() != 0) begin
            failures++;
            $display("FAIL leftover got done=%0d wr=%0d pending want=0", exp_done.size(), exp_wr.size());
         end
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $finish;
      end
   end

   task automatic put(input logic [7:0] a, input logic [15:0] d);
      ld_a = a;
      ld_d = d;
      ld_en = 1'b1;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   task automatic ed(input logic [7:0] p, input logic [2:0] f);
      exp_done.push_back({p, f});
   endtask

   task automatic ins(input logic [7:0] a, input logic [15:0] d, input logic [7:0] p, input logic [2:0] f);
      put(a, d);
      ed(p, f);
   endtask

   task automatic snap(input logic [7:0] a, input logic [15:0] d, input logic [7:0] p, input logic [2:0] f);
      snap_q.push_back({a, d, 1'b0, 1'b0, p, f});
   endtask

   task automatic wait_dones(input int n);
      int seen = 0;
      int cycles = 0;
      while (seen < n && cycles < 3000) begin
         @(negedge clk);
         cycles++;
         if (done) seen++;
      end
      if (seen < n) tmo++;
   endtask

   initial begin
      #1 snap(8'h00, 16'h0000, 8'h00, 3'b000);
      // Program 1: arithmetic, flags, load/store, branches, jumps, PC wrap
      ins(8'h00, 16'h1005, 8'h01, 3'b000);
      ins(8'h01, 16'h1203, 8'h02, 3'b000);
      ins(8'h02, 16'h6001, 8'h03, 3'b001);
      ins(8'h03, 16'hA001, 8'h04, 3'b001);
      ins(8'h04, 16'h6201, 8'h05, 3'b011);
      ins(8'h05, 16'hA200, 8'h06, 3'b011);
      ins(8'h06, 16'hE1FF, 8'h07, 3'b011);
      ins(8'h07, 16'h507F, 8'h08, 3'b100);
      ins(8'h08, 16'h51FF, 8'h09, 3'b001);
      ins(8'h09, 16'hE5FF, 8'h0A, 3'b001);
      ins(8'h0A, 16'h1240, 8'h0B, 3'b001);
      ins(8'h0B, 16'hE024, 8'h0C, 3'b001);
      ins(8'h0C, 16'h5034, 8'h0D, 3'b000);
      ins(8'h0D, 16'hA001, 8'h0E, 3'b000);
      ins(8'h0E, 16'h8601, 8'h0F, 3'b000);
      ins(8'h0F, 16'hA602, 8'h10, 3'b000);
      ins(8'h10, 16'hA401, 8'h11, 3'b000);
      ins(8'h11, 16'h6603, 8'h12, 3'b011);
      ins(8'h12, 16'h2201, 8'h14, 3'b011);
      put(8'h13, 16'h1077);
      ins(8'h14, 16'h2401, 8'h15, 3'b011);
      ins(8'h15, 16'h2E01, 8'h16, 3'b011);
      ins(8'h16, 16'h2801, 8'h18, 3'b011);
      put(8'h17, 16'h1077);
      ins(8'h18, 16'h2DFE, 8'h19, 3'b011);
      ins(8'h19, 16'h1E28, 8'h28, 3'b011);
      ins(8'h28, 16'h0807, 8'h29, 3'b011);
      ins(8'h29, 16'hA801, 8'h2A, 3'b011);
      ins(8'h2A, 16'h1EFF, 8'hFF, 3'b011);
      ins(8'hFF, 16'h1A01, 8'h00, 3'b011);
      exp_wr.push_back({8'h03, 16'h0002});
      exp_wr.push_back({8'h02, 16'h0000});
      exp_wr.push_back({8'h40, 16'h1234});
      exp_wr.push_back({8'h80, 16'h1234});
      exp_wr.push_back({8'h40, 16'hFF80});
      exp_wr.push_back({8'h40, 16'h0029});
      exp_cyc.push_back(4);
      exp_cyc.push_back(8);
      exp_cyc.push_back(14);
      run = 1'b1;
      reset = 1'b0;
      wait_dones(27);
      repeat (2) @(negedge clk);
      run = 1'b0;
      repeat (12) @(negedge clk);
      #1 snap(8'hFF, 16'h0029, 8'h00, 3'b011);
      @(negedge clk);
      // Asynchronous reset between clock edges
      @(posedge clk);
      #1 reset = 1'b1;
      snap(8'h00, 16'h0000, 8'h00, 3'b000);
      @(negedge clk);
      // Program 2: beq at 3 taken then not taken; reset aborts add in E1
      put(8'h00, 16'h1201);
      put(8'h01, 16'h1401);
      put(8'h02, 16'h6202);
      put(8'h03, 16'h23FE);
      put(8'h04, 16'h5001);
      ed(8'h01, 3'b000);
      ed(8'h02, 3'b000);
      ed(8'h03, 3'b011);
      ed(8'h02, 3'b011);
      ed(8'h03, 3'b100);
      ed(8'h04, 3'b100);
      run = 1'b1;
      reset = 1'b0;
      wait_dones(6);
      repeat (4) @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      snap(8'h00, 16'h0000, 8'h00, 3'b000);
      @(negedge clk);
      // Program 3: restart from 0 with cleared registers; run dropped in F1
      put(8'h00, 16'hA202);
      ed(8'h01, 3'b000);
      exp_wr.push_back({8'h00, 16'h0000});
      exp_cyc.push_back(5);
      run = 1'b1;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      run = 1'b0;
      repeat (12) @(negedge clk);
      #1 snap(8'h00, 16'h0000, 8'h01, 3'b000);
      @(negedge clk);
      #1 end_req = 1'b1;
   end

   initial begin
      #300000;
      $display("FAIL watchdog got=no finish want=finish");
      $fatal(1, "watchdog");
   end
endmodule
